// File: rtl/hht_spmv_engine_pkg.sv
// Shared types and default widths for the CSR SpMV engine.
// State encoding for the row walker FSM.
package hht_pkg;
  localparam int DW_D   = 32;
  localparam int AW_D   = 32;
  localparam int ACCW_D = 64;

  typedef enum logic [2:0] {
    IDLE,
    PTR0,
    PTR1,
    COL,
    VEC,
    EMIT,
    FIN
  } state_t;
endpackage

// File: rtl/hht_spmv_engine_if.sv
// Result stream of the SpMV engine: one row sum per beat.
// Master is the engine, slave is the consumer.
interface hht_spmv_engine_if #(
  parameter int AW   = 32,
  parameter int ACCW = 64
) ();
  logic            y_valid;
  logic            y_ready;
  logic [AW-1:0]   y_row;
  logic [ACCW-1:0] y_data;

  modport master (
    output y_valid, y_row, y_data,
    input  y_ready
  );
  modport slave (
    input  y_valid, y_row, y_data,
    output y_ready
  );
endinterface

// File: rtl/hht_spmv_engine_mac.sv
// Row accumulator: acc += a*b, optional saturation at all-ones.
// The extra sum bit is the overflow flag.
module hht_mac #(
  parameter int DW   = 32,
  parameter int ACCW = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            sat,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] acc
);
  logic [2*DW-1:0] prod;
  logic [ACCW:0]   sum;

  assign prod = a * b;
  assign sum  = {1'b0, acc} + (ACCW+1)'(prod);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= (sat && sum[ACCW]) ? '1 : sum[ACCW-1:0];
    end
  end
endmodule

// File: rtl/hht_spmv_engine.sv
// CSR sparse-matrix x dense-vector engine.
// Walks row_ptr/col_idx/val/vec and streams one sum per row.
module hht_spmv_engine
  import hht_pkg::*;
#(
  parameter int DW   = DW_D,
  parameter int AW   = AW_D,
  parameter int ACCW = ACCW_D,
  parameter bit SAT  = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [AW-1:0] n_rows,
  input  logic [AW-1:0] row_base,
  input  logic [AW-1:0] col_base,
  input  logic [AW-1:0] val_base,
  input  logic [AW-1:0] vec_base,
  output logic [AW-1:0] addr1,
  input  logic [DW-1:0] dataIn1,
  output logic [AW-1:0] addr2,
  input  logic [DW-1:0] dataIn2,
  hht_spmv_engine_if.master y_if,
  output logic          busy,
  output logic          done,
  output logic          err
);
  state_t state, state_n;

  logic [AW-1:0]   nr, rb, cb, vb, xb, r;
  logic [DW-1:0]   kb, ke, k, c, v;
  logic [ACCW-1:0] acc;
  logic            mac_clr, mac_en, err_q;

  hht_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk   (Clk),
    .rst_n (Rst),
    .clr   (mac_clr),
    .en    (mac_en),
    .sat   (SAT),
    .a     (v),
    .b     (dataIn2),
    .acc   (acc)
  );

  always_comb begin
    state_n = state;
    addr1   = '0;
    addr2   = '0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = PTR0;
      PTR0: begin
        addr1   = rb;
        state_n = (nr == '0) ? FIN : PTR1;
      end
      PTR1: begin
        addr1   = rb + r + AW'(1);
        mac_clr = 1'b1;
        // empty and malformed rows both go straight to EMIT
        state_n = (dataIn1 > kb) ? COL : EMIT;
      end
      COL: begin
        addr1   = cb + AW'(k);
        addr2   = vb + AW'(k);
        state_n = VEC;
      end
      VEC: begin
        addr2   = xb + AW'(c);
        mac_en  = 1'b1;
        state_n = (k + DW'(1) < ke) ? COL : EMIT;
      end
      EMIT: begin
        if (y_if.y_ready)
          state_n = (r + AW'(1) == nr) ? FIN : PTR1;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      nr    <= '0;
      rb    <= '0;
      cb    <= '0;
      vb    <= '0;
      xb    <= '0;
      r     <= '0;
      kb    <= '0;
      ke    <= '0;
      k     <= '0;
      c     <= '0;
      v     <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (start) begin
          nr    <= n_rows;
          rb    <= row_base;
          cb    <= col_base;
          vb    <= val_base;
          xb    <= vec_base;
          r     <= '0;
          err_q <= 1'b0;
        end
        PTR0: kb <= dataIn1;
        PTR1: begin
          ke <= dataIn1;
          k  <= kb;
          if (dataIn1 < kb) err_q <= 1'b1;
        end
        COL: begin
          c <= dataIn1;
          v <= dataIn2;
        end
        VEC: k <= k + DW'(1);
        EMIT: if (y_if.y_ready) begin
          r  <= r + AW'(1);
          kb <= ke;
        end
        default: ;
      endcase
    end
  end

  assign y_if.y_valid = (state == EMIT);
  assign y_if.y_row   = y_if.y_valid ? r : '0;
  assign y_if.y_data  = y_if.y_valid ? acc : '0;
  assign busy         = (state != IDLE);
  assign done         = (state == FIN);
  assign err          = err_q;
endmodule
